// File: rtl/wash_pkg.sv
// Shared definitions for the washing-machine sequencer and its phase timer.
// Holds the 3-bit phase codes, the state type, and the rinse/watchdog widths.
// No logic; constants and types only.
package wash_pkg;

    // Phase codes, also decoded by the phase timer.
    localparam logic [2:0] ST_IDLE    = 3'b000;
    localparam logic [2:0] ST_SUPPLY  = 3'b001;
    localparam logic [2:0] ST_WASH    = 3'b011;
    localparam logic [2:0] ST_WATER   = 3'b010;
    localparam logic [2:0] ST_DEWATER = 3'b110;
    localparam logic [2:0] ST_ALARM   = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_SUPPLY  = ST_SUPPLY,
        S_WASH    = ST_WASH,
        S_WATER   = ST_WATER,
        S_DEWATER = ST_DEWATER,
        S_ALARM   = ST_ALARM
    } state_t;

    localparam int RINSE_W = 4;
    localparam int WDOG_W  = 16;

endpackage

// File: rtl/key_rise_detect.sv
// Synchronous rising-edge detector for a level key input.
// Ports: clk, reset (async active-low), d (level in), rise (d high now, low last clk).
// RESET_VAL sets the remembered level after reset; 1 suppresses a key held through reset.
module key_rise_detect #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_q <= RESET_VAL;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/wash_sequencer.sv
// Washing-machine sequencer: IDLE -> (SUPPLY -> WASH -> WATER) x RINSE_CYCLES -> DEWATER -> ALARM -> IDLE.
// Ports: clk/reset; start key, water_full sensor, timer done flags in; state_out code,
//   actuator enables, rinse_left, busy, fault out. All outputs are registered-state decodes;
//   one clk from a qualifying input to the new state. Build macro WASH_SEQ_SUPPLY_TIMEOUT_EN
//   enables the supply watchdog (SUPPLY -> ALARM with sticky fault after SUPPLY_TIMEOUT clks).
module wash_sequencer
    import wash_pkg::*;
#(
    parameter int RINSE_CYCLES   = 2,
    parameter int SUPPLY_TIMEOUT = 600
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               water_full,
    input  logic               wash_done,
    input  logic               water_done,
    input  logic               dewater_done,
    input  logic               alarm_done,
    output logic [2:0]         state_out,
    output logic               inlet_valve,
    output logic               motor_run,
    output logic               drain_valve,
    output logic               motor_spin,
    output logic               buzzer,
    output logic [RINSE_W-1:0] rinse_left,
    output logic               busy,
    output logic               fault
);

    if (RINSE_CYCLES < 1 || RINSE_CYCLES > 15) begin : g_bad_rinse
        $error("wash_sequencer: RINSE_CYCLES must be 1..15");
    end
    if (SUPPLY_TIMEOUT < 2 || SUPPLY_TIMEOUT > 65535) begin : g_bad_timeout
        $error("wash_sequencer: SUPPLY_TIMEOUT must be 2..65535");
    end

    localparam logic [RINSE_W-1:0] RINSE_INIT = RINSE_W'(RINSE_CYCLES);

    state_t             state_q, state_d;
    logic [RINSE_W-1:0] rinse_q, rinse_d;
    logic               fault_q, fault_d;
    logic               start_rise;
    logic               timeout;

    // Reset value 1: a start key already held when reset releases is not a command.
    key_rise_detect #(
        .RESET_VAL (1'b1)
    ) u_start_rise (
        .clk   (clk),
        .reset (reset),
        .d     (start),
        .rise  (start_rise)
    );

`ifdef WASH_SEQ_SUPPLY_TIMEOUT_EN
    localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(SUPPLY_TIMEOUT - 1);

    logic [WDOG_W-1:0] wdog_q;

    // Held at zero outside SUPPLY, so every SUPPLY entry starts counting from 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdog_q <= '0;
        end else if (state_q != S_SUPPLY) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_q + 1'b1;
        end
    end

    assign timeout = (wdog_q == WDOG_LIMIT);
`else
    // Without the watchdog SUPPLY waits forever and fault can never set.
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            rinse_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rinse_q <= rinse_d;
            fault_q <= fault_d;
        end
    end

    // Each state looks only at its own flag, so stale level flags from
    // earlier phases cannot advance the sequence.
    always_comb begin
        state_d = state_q;
        rinse_d = rinse_q;
        fault_d = fault_q;
        case (state_q)
            S_IDLE: begin
                if (start_rise) begin
                    state_d = S_SUPPLY;
                    rinse_d = RINSE_INIT;
                    fault_d = 1'b0;
                end
            end
            S_SUPPLY: begin
                // water_full wins over a watchdog expiring in the same cycle.
                if (water_full) begin
                    state_d = S_WASH;
                end else if (timeout) begin
                    state_d = S_ALARM;
                    rinse_d = '0;
                    fault_d = 1'b1;
                end
            end
            S_WASH: begin
                if (wash_done) begin
                    state_d = S_WATER;
                end
            end
            S_WATER: begin
                if (water_done) begin
                    if (rinse_q > RINSE_W'(1)) begin
                        state_d = S_SUPPLY;
                        rinse_d = rinse_q - RINSE_W'(1);
                    end else begin
                        state_d = S_DEWATER;
                        rinse_d = '0;
                    end
                end
            end
            S_DEWATER: begin
                if (dewater_done) begin
                    state_d = S_ALARM;
                end
            end
            S_ALARM: begin
                if (alarm_done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign state_out   = state_q;
    assign inlet_valve = (state_q == S_SUPPLY);
    assign motor_run   = (state_q == S_WASH);
    assign drain_valve = (state_q == S_WATER) || (state_q == S_DEWATER);
    assign motor_spin  = (state_q == S_DEWATER);
    assign buzzer      = (state_q == S_ALARM);
    assign rinse_left  = rinse_q;
    assign busy        = (state_q != S_IDLE);
    assign fault       = fault_q;

endmodule

// File: tb/tb_wash_sequencer.sv
// Bench for wash_sequencer: two instances (RINSE_CYCLES 2 and 1) share one input stream.
// A phase-level model predicts every output each cycle; directed runs pin the model with
// literal sequences, then random stimulus with occasional async resets follows.
module tb_wash_sequencer;

    localparam int P_IDLE  = 0;
    localparam int P_SUP   = 1;
    localparam int P_WASH  = 2;
    localparam int P_WATER = 3;
    localparam int P_DEW   = 4;
    localparam int P_ALM   = 5;
    localparam int TO      = 600;

    logic clk;
    logic reset;
    logic start, water_full, wash_done, water_done, dewater_done, alarm_done;

    logic [2:0] so [2];
    logic [3:0] rl [2];
    logic       iv [2], mr [2], dv [2], ms [2], bz [2], by [2], ft [2];

    int n_cmp  = 0;
    int n_fail = 0;

    wash_sequencer #(.RINSE_CYCLES(2), .SUPPLY_TIMEOUT(TO)) u_a (
        .clk(clk), .reset(reset), .start(start), .water_full(water_full),
        .wash_done(wash_done), .water_done(water_done), .dewater_done(dewater_done),
        .alarm_done(alarm_done), .state_out(so[0]), .inlet_valve(iv[0]), .motor_run(mr[0]),
        .drain_valve(dv[0]), .motor_spin(ms[0]), .buzzer(bz[0]), .rinse_left(rl[0]),
        .busy(by[0]), .fault(ft[0]));

    wash_sequencer #(.RINSE_CYCLES(1), .SUPPLY_TIMEOUT(TO)) u_b (
        .clk(clk), .reset(reset), .start(start), .water_full(water_full),
        .wash_done(wash_done), .water_done(water_done), .dewater_done(dewater_done),
        .alarm_done(alarm_done), .state_out(so[1]), .inlet_valve(iv[1]), .motor_run(mr[1]),
        .drain_valve(dv[1]), .motor_spin(ms[1]), .buzzer(bz[1]), .rinse_left(rl[1]),
        .busy(by[1]), .fault(ft[1]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    int code_of [6] = '{0, 1, 3, 2, 6, 4};
    int m_phase [2];
    int m_rinse [2];
    bit m_fault [2];
    int m_cyc   [2];   // clks spent in the current phase, 0 on entry
    bit m_sq;
    int nx_phase [2];
    int nx_rinse [2];
    bit nx_fault [2];

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            nx_phase[k] = m_phase[k];
            nx_rinse[k] = m_rinse[k];
            nx_fault[k] = m_fault[k];
            case (m_phase[k])
                P_IDLE: if (start && !m_sq) begin
                    nx_phase[k] = P_SUP;
                    nx_rinse[k] = (k == 0) ? 2 : 1;
                    nx_fault[k] = 1'b0;
                end
                P_SUP: begin
                    if (water_full) nx_phase[k] = P_WASH;
`ifdef WASH_SEQ_SUPPLY_TIMEOUT_EN
                    else if (m_cyc[k] == TO - 1) begin
                        nx_phase[k] = P_ALM;
                        nx_fault[k] = 1'b1;
                        nx_rinse[k] = 0;
                    end
`endif
                end
                P_WASH:  if (wash_done) nx_phase[k] = P_WATER;
                P_WATER: if (water_done) begin
                    nx_rinse[k] = m_rinse[k] - 1;
                    nx_phase[k] = (m_rinse[k] > 1) ? P_SUP : P_DEW;
                end
                P_DEW:   if (dewater_done) nx_phase[k] = P_ALM;
                default: if (alarm_done) nx_phase[k] = P_IDLE;
            endcase
        end
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                m_phase[k] <= P_IDLE;
                m_rinse[k] <= 0;
                m_fault[k] <= 1'b0;
                m_cyc[k]   <= 0;
            end
            m_sq <= 1'b1;
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_phase[k] <= nx_phase[k];
                m_rinse[k] <= nx_rinse[k];
                m_fault[k] <= nx_fault[k];
                m_cyc[k]   <= (nx_phase[k] != m_phase[k]) ? 0 : m_cyc[k] + 1;
            end
            m_sq <= start;
        end
    end

    // ---------------- checking ----------------
    int sa[$], sb[$], ra[$], rb[$];
    bit rec_en = 1'b0;
    int last_s [2] = '{0, 0};
    int last_r [2] = '{0, 0};

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Advance to the next falling edge and compare every output of both DUTs to the model.
    task automatic tick();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            int ph;
            ph = m_phase[k];
            check($sformatf("state_out[%0d]", k),   so[k], code_of[ph]);
            check($sformatf("inlet_valve[%0d]", k), iv[k], int'(ph == P_SUP));
            check($sformatf("motor_run[%0d]", k),   mr[k], int'(ph == P_WASH));
            check($sformatf("drain_valve[%0d]", k), dv[k], int'(ph == P_WATER || ph == P_DEW));
            check($sformatf("motor_spin[%0d]", k),  ms[k], int'(ph == P_DEW));
            check($sformatf("buzzer[%0d]", k),      bz[k], int'(ph == P_ALM));
            check($sformatf("rinse_left[%0d]", k),  rl[k], m_rinse[k]);
            check($sformatf("busy[%0d]", k),        by[k], int'(ph != P_IDLE));
            check($sformatf("fault[%0d]", k),       ft[k], int'(m_fault[k]));
        end
        if (rec_en) begin
            if (int'(so[0]) != last_s[0]) begin sa.push_back(int'(so[0])); last_s[0] = int'(so[0]); end
            if (int'(so[1]) != last_s[1]) begin sb.push_back(int'(so[1])); last_s[1] = int'(so[1]); end
            if (int'(rl[0]) != last_r[0]) begin ra.push_back(int'(rl[0])); last_r[0] = int'(rl[0]); end
            if (int'(rl[1]) != last_r[1]) begin rb.push_back(int'(rl[1])); last_r[1] = int'(rl[1]); end
        end
    endtask

    // Directed stimulus keyed off instance A's phase: water after 5 clk, a start pulse
    // inside WASH, wash_done left high through WATER, other flags after a few clk.
    task automatic drive_rules(input bit hold_dw);
        int ph, cy;
        ph = m_phase[0];
        cy = m_cyc[0];
        start        = (ph == P_WASH && cy == 1);
        water_full   = (ph == P_SUP && cy >= 5);
        wash_done    = (ph == P_WASH && cy >= 2) || (ph == P_WATER);
        water_done   = (ph == P_WATER && cy >= 3);
        dewater_done = (ph == P_DEW && cy >= 2 && !hold_dw);
        alarm_done   = (ph == P_ALM && cy >= 2);
    endtask

    int exp_sa [9] = '{1, 3, 2, 1, 3, 2, 6, 4, 0};
    int exp_sb [6] = '{1, 3, 2, 6, 4, 0};
    int exp_ra [3] = '{2, 1, 0};
    int exp_rb [2] = '{1, 0};

    initial begin
        reset = 1'b0; start = 1'b1;
        water_full = 1'b0; wash_done = 1'b0; water_done = 1'b0;
        dewater_done = 1'b0; alarm_done = 1'b0;

        // Reset values, with start held high across reset release.
        repeat (2) tick();
        check("reset_state", so[0], 0);
        check("reset_rinse", rl[0], 0);
        check("reset_busy",  by[0], 0);
        reset = 1'b1;
        repeat (4) tick();
        check("held_start_idle", so[0], 0);
        check("held_start_idle_b", so[1], 0);

        // Nominal run through both passes.
        start = 1'b0;
        tick();
        rec_en = 1'b1;
        start = 1'b1;
        tick();
        for (int i = 0; i < 300 && m_phase[0] != P_IDLE; i++) begin
            drive_rules(1'b0);
            tick();
        end
        rec_en = 1'b0;
        check("nominal_ends_idle", so[0], 0);
        check("seq_a_len", sa.size(), 9);
        for (int i = 0; i < 9 && i < sa.size(); i++) check($sformatf("seq_a[%0d]", i), sa[i], exp_sa[i]);
        check("seq_b_len", sb.size(), 6);
        for (int i = 0; i < 6 && i < sb.size(); i++) check($sformatf("seq_b[%0d]", i), sb[i], exp_sb[i]);
        check("rinse_a_len", ra.size(), 3);
        for (int i = 0; i < 3 && i < ra.size(); i++) check($sformatf("rinse_a[%0d]", i), ra[i], exp_ra[i]);
        check("rinse_b_len", rb.size(), 2);
        for (int i = 0; i < 2 && i < rb.size(); i++) check($sformatf("rinse_b[%0d]", i), rb[i], exp_rb[i]);

        // Reset while instance A is spinning.
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        for (int i = 0; i < 300 && m_phase[0] != P_DEW; i++) begin
            drive_rules(1'b1);
            tick();
        end
        drive_rules(1'b1);
        tick();
        check("dewater_reached", so[0], 6);
        check("dewater_spin", ms[0], 1);
        #2 reset = 1'b0;
        #1;
        check("async_reset_state", so[0], 0);
        check("async_reset_spin",  ms[0], 0);
        check("async_reset_drain", dv[0], 0);
        tick();
        reset = 1'b1;
        start = 1'b0;
        dewater_done = 1'b0; water_full = 1'b0; wash_done = 1'b0; water_done = 1'b0;
        tick();
        start = 1'b1;
        tick();
        check("restart_state", so[0], 1);
        check("restart_rinse_a", rl[0], 2);
        check("restart_rinse_b", rl[1], 1);
        check("restart_inlet", iv[0], 1);

`ifdef WASH_SEQ_SUPPLY_TIMEOUT_EN
        begin
            int n;
            reset = 1'b0;
            tick();
            reset = 1'b1;
            start = 1'b0;
            tick();
            start = 1'b1;
            tick();
            start = 1'b0;
            n = 0;
            while (so[0] != 3'd4 && n < 700) begin
                tick();
                n++;
            end
            check("timeout_clks", n, 600);
            check("timeout_fault", ft[0], 1);
            check("timeout_buzzer", bz[0], 1);
            check("timeout_rinse", rl[0], 0);
            alarm_done = 1'b1;
            tick();
            alarm_done = 1'b0;
            check("timeout_idle", so[0], 0);
            check("fault_sticky", ft[0], 1);
            start = 1'b1;
            tick();
            start = 1'b0;
            check("fault_cleared", ft[0], 0);
            check("fault_restart_state", so[0], 1);
            for (int i = 0; i < 700 && m_cyc[0] < TO - 1; i++) tick();
            water_full = 1'b1;
            tick();
            water_full = 1'b0;
            check("limit_tie_wash", so[0], 3);
            check("limit_tie_fault", ft[0], 0);
        end
`endif

        // Random stimulus.
        for (int i = 0; i < 4000; i++) begin
            tick();
            reset        = ($urandom_range(0, 299) != 0);
            start        = ($urandom_range(0, 5) == 0);
            water_full   = ($urandom_range(0, 3) == 0);
            wash_done    = ($urandom_range(0, 3) == 0);
            water_done   = ($urandom_range(0, 3) == 0);
            dewater_done = ($urandom_range(0, 3) == 0);
            alarm_done   = ($urandom_range(0, 3) == 0);
        end
        reset = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/wash_sequencer.md
# wash_sequencer

Top-level washing-machine sequencer. Drives the 3-bit state code into the phase timer and advances on the timer's done flags. Repeats the supply/wash/drain loop a configurable number of times, then spins, then alarms. Also drives the actuator enables (valves, motor, buzzer) from its state register.

## Interface
- RINSE_CYCLES, 2: number of supply→wash→drain passes before spin. Legal range 1..15.
- SUPPLY_TIMEOUT, 600: supply watchdog limit in clk cycles (10 Hz tick, so 600 = 60 s). Used only with the macro; legal range 2..65535.
- clk  in  1  10 Hz tick clock, shared with the phase timer.
- reset  in  1  reset, asynchronous, active-low.
- start  in  1  start key, level; a rising edge is the command.
- water_full  in  1  tub level sensor, high = full.
- wash_done, water_done, dewater_done, alarm_done  in  1 each  timer flags. Level signals; the timer clears them while state_out is IDLE or SUPPLY.
- state_out  out  3  phase code: IDLE 000, SUPPLY 001, WASH 011, WATER 010, DEWATER 110, ALARM 100.
- inlet_valve, motor_run, drain_valve, motor_spin, buzzer  out  1 each  actuator enables.
- rinse_left  out  4  passes remaining, including the current pass.
- busy  out  1  high when state_out is not IDLE.
- fault  out  1  supply-timeout fault, sticky.

## Operation
- Moore FSM. All outputs decode from registered state and counters; none come from inputs.
- IDLE: a start rising edge → SUPPLY, with rinse_left ← RINSE_CYCLES and fault ← 0.
- SUPPLY: water_full=1 → WASH.
- WASH: wash_done=1 → WATER.
- WATER: water_done=1 and rinse_left>1 → SUPPLY, with rinse_left−1.
- WATER: water_done=1 and rinse_left==1 → DEWATER, with rinse_left ← 0.
- DEWATER: dewater_done=1 → ALARM.
- ALARM: alarm_done=1 → IDLE.
- Each state acts only on its own done flag. Stale flags from earlier phases (e.g. wash_done still high during WATER) are ignored.
- start edges outside IDLE are ignored. There is no abort; only reset aborts.
- Actuator decode:
  - inlet_valve = SUPPLY
  - motor_run = WASH
  - drain_valve = WATER or DEWATER
  - motor_spin = DEWATER
  - buzzer = ALARM
- Undefined state codes (101, 111) → IDLE on the next clk.

## Timing
- Reset values:
  - state_out=000, rinse_left=0, fault=0, busy=0
  - all actuator outputs 0
  - start edge register=1, so a start held high through reset release does not launch a cycle.
- Edge detect: start_q is registered each clk. The edge is start & ~start_q.
- Latency: one clk from a qualifying input (start edge, water_full, or done flag) to the new state_out and actuator values.
- Reset asserted mid-cycle: all outputs drop to reset values immediately (asynchronous). Sequencing resumes only on a new start edge.
- water_full already high on entry to SUPPLY: SUPPLY lasts exactly one clk.

## Configuration
- WASH_SEQ_SUPPLY_TIMEOUT_EN defined:
  - A 16-bit counter clears on SUPPLY entry and increments each clk in SUPPLY.
  - If it reaches SUPPLY_TIMEOUT−1 with water_full=0, the next clk goes to ALARM with fault ← 1 and rinse_left ← 0.
  - ALARM then exits on alarm_done as normal; fault stays 1 until the next start edge.
  - If water_full=1 in the same cycle as the limit, water_full wins → WASH, no fault.
- Macro not defined:
  - No counter; SUPPLY waits indefinitely.
  - fault is tied to 0.

## Structure
- Package wash_pkg holds:
  - the six 3-bit state constants (shared with the phase timer)
  - the state typedef
  - rinse counter width 4 and watchdog width 16.
- One sub-module, key_rise_detect: 1-bit synchronous rising-edge detector with a reset value parameter. Used for start.
- FSM, rinse counter and watchdog stay in wash_sequencer.

## Test plan
- Nominal, RINSE_CYCLES=2: start edge, water_full after 5 clk, done flags pulsed → state sequence 001,011,010,001,011,010,110,100,000; rinse_left goes 2,1,0; actuators match state in each phase.
- RINSE_CYCLES=1: after the first water_done, state_out goes 010→110 directly; rinse_left=0.
- Stale and ignored inputs:
  - wash_done held high through WATER → no transition until water_done.
  - start pulse during WASH → no effect.
  - start held high across reset release → stays IDLE.
- Reset mid-DEWATER: drive reset low → state_out=000 and motor_spin=0 without waiting for clk. A new start edge → SUPPLY with rinse_left=2.
- Macro on, SUPPLY_TIMEOUT=600, water_full=0 → ALARM entered 600 clk after SUPPLY entry, fault=1, buzzer=1; alarm_done → IDLE with fault still 1; next start clears fault.
- Macro on, water_full rising in the same cycle the counter hits 599 → WASH, fault=0.
